slice_regfile_wb: RTL and testbench

Write-back register file for the 4-bit-addressed ALU bit-slice. It buffers slice results and commits them into 16 registers, then drives those registers back to the slice's 16:1 operand mux. It also holds the carry and zero status flags. It sits directly downstream of the slice's ALU output and directly upstream of its operand-select mux, closing the datapath loop.

---
 rtl/slice_pkg.sv | 20 ++
 rtl/slice_wb_fifo2.sv | 80 ++++++++
 rtl/slice_regfile_wb.sv | 133 +++++++++++++
 tb/tb_slice_regfile_wb.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// rtl/slice_pkg.sv - shared constants and write-back entry type for the ALU bit-slice
//
// Purpose: register-file geometry and the single-slice write-back entry layout
// {addr, data, cout, flag_we}, shared by the ALU side and the register file.
// No ports (package).

package slice_pkg;

    localparam int SLICE_ADDR_W = 4;
    localparam int SLICE_NREG   = 16;
    localparam int SLICE_DATA_W = 1;

    typedef struct packed {
        logic [SLICE_ADDR_W-1:0] addr;
        logic [SLICE_DATA_W-1:0] data;
        logic                    cout;
        logic                    flag_we;
    } slice_wb_entry_t;

endpackage

// File: rtl/slice_wb_fifo2.sv
// rtl/slice_wb_fifo2.sv - generic 2-entry FIFO for the write-back queue
//
// Purpose: two-slot queue; slot 0 is always the head, so a pop shifts slot 1
// down. Push and pop on the same edge keep the occupancy unchanged.
// Ports:
//   clk, rst        clock, synchronous active-high flush
//   push_i, pop_i   enqueue din_i / dequeue head (ignored when empty)
//   din_i           entry to enqueue
//   head_o, tail_o  oldest / newest entry (equal when count_o == 1)
//   count_o         occupancy 0..2

module slice_wb_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic [W-1:0] tail_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // A push into a full queue is only legal when the head leaves that edge.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (count_q == 2'd0) begin
            if (do_push) begin
                slot0_d = din_i;
                count_d = 2'd1;
            end
        end else if (count_q == 2'd1) begin
            if (do_push && do_pop) begin
                slot0_d = din_i;
            end else if (do_push) begin
                slot1_d = din_i;
                count_d = 2'd2;
            end else if (do_pop) begin
                count_d = 2'd0;
            end
        end else begin
            if (do_pop) begin
                slot0_d = slot1_q;
                if (do_push) begin
                    slot1_d = din_i;
                end else begin
                    count_d = 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign tail_o  = (count_q == 2'd2) ? slot1_q : slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/slice_regfile_wb.sv
// rtl/slice_regfile_wb.sv - write-back register file with carry/zero flags
//
// Purpose: queues ALU results in a 2-entry FIFO, commits the head into one of
// 16 registers when hold is low, updates carry/zero on flagged commits, and
// drives the operand read port.
// Optional feature macro: SLICE_WB_BYPASS_EN (read port forwards pending entries).
// Ports:
//   clk, rst, clr       clock, synchronous reset, synchronous clear (same effect)
//   wb_valid/wb_ready   write-back handshake; wb_addr/wb_data/wb_cout/wb_flag_we payload
//   hold                stall commit
//   rd_addr/rd_data     combinational operand read
//   regs_q              committed registers, register i at [i*WIDTH +: WIDTH]
//   carry_q, zero_q     status flags
//   pend_cnt            pending-queue occupancy

module slice_regfile_wb
    import slice_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = SLICE_NREG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [SLICE_ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    wb_cout,
    input  logic                    wb_flag_we,
    input  logic                    hold,
    input  logic [SLICE_ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic [DEPTH*WIDTH-1:0]  regs_q,
    output logic                    carry_q,
    output logic                    zero_q,
    output logic [1:0]              pend_cnt
);

    // Same layout as slice_wb_entry_t, widened to this instance's data width.
    typedef struct packed {
        logic [SLICE_ADDR_W-1:0] addr;
        logic [WIDTH-1:0]        data;
        logic                    cout;
        logic                    flag_we;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [WIDTH-1:0] regs_mem_q [DEPTH];
    logic [WIDTH-1:0] regs_d     [DEPTH];
    logic             carry_d, zero_d;

    logic             flush, push, commit;
    entry_t           push_entry, head, tail;
    logic [ENTRY_W-1:0] head_raw, tail_raw;

    assign flush = rst || clr;

    // Ready depends only on occupancy and the reset/clear inputs, never on wb_valid.
    assign wb_ready = (pend_cnt != 2'd2) && !flush;
    assign push     = wb_valid && wb_ready;
    assign commit   = (pend_cnt != 2'd0) && !hold;

    assign push_entry = '{addr: wb_addr, data: wb_data, cout: wb_cout, flag_we: wb_flag_we};

    slice_wb_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (flush),
        .push_i  (push),
        .pop_i   (commit),
        .din_i   (push_entry),
        .head_o  (head_raw),
        .tail_o  (tail_raw),
        .count_o (pend_cnt)
    );

    assign head = entry_t'(head_raw);
    assign tail = entry_t'(tail_raw);

    always_comb begin
        regs_d  = regs_mem_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        if (commit) begin
            regs_d[head.addr] = head.data;
            if (head.flag_we) begin
                carry_d = head.cout;
                zero_d  = (head.data == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_mem_q[i] <= '0;
            end
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            regs_mem_q <= regs_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_q[i*WIDTH +: WIDTH] = regs_mem_q[i];
        end
    end

`ifdef SLICE_WB_BYPASS_EN
    // Tail is the newest entry, so it is checked last and overrides the head.
    always_comb begin
        rd_data = regs_mem_q[rd_addr];
        if ((pend_cnt == 2'd2) && (head.addr == rd_addr)) begin
            rd_data = head.data;
        end
        if ((pend_cnt != 2'd0) && (tail.addr == rd_addr)) begin
            rd_data = tail.data;
        end
    end
`else
    always_comb begin
        rd_data = regs_mem_q[rd_addr];
    end
`endif

endmodule

// File: tb/tb_slice_regfile_wb.sv
// tb/tb_slice_regfile_wb.sv - self-checking bench for slice_regfile_wb

module tb_slice_regfile_wb;

    localparam int W = 4;
`ifdef SLICE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst, clr;
    logic          wb_valid, wb_ready;
    logic [3:0]    wb_addr;
    logic [W-1:0]  wb_data;
    logic          wb_cout, wb_flag_we, hold;
    logic [3:0]    rd_addr;
    logic [W-1:0]  rd_data;
    logic [16*W-1:0] regs_q;
    logic          carry_q, zero_q;
    logic [1:0]    pend_cnt;

    int checks = 0;
    int errors = 0;

    slice_regfile_wb #(.WIDTH(W), .DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_cout    (wb_cout),
        .wb_flag_we (wb_flag_we),
        .hold       (hold),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .regs_q     (regs_q),
        .carry_q    (carry_q),
        .zero_q     (zero_q),
        .pend_cnt   (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of pending writes plus committed state.
    typedef struct {
        logic [3:0]   addr;
        logic [W-1:0] data;
        logic         cout;
        logic         fw;
    } ment_t;

    ment_t        mq[$];
    logic [W-1:0] mregs[16];
    logic         mc, mz;

    function automatic logic [W-1:0] rq(input int i);
        return regs_q[i*W +: W];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 0; clr = 0; wb_valid = 0; hold = 0;
        wb_addr = 0; wb_data = 0; wb_cout = 0; wb_flag_we = 0; rd_addr = 0;
    endtask

    task automatic push_req(input int a, input int d, input bit c, input bit fw);
        wb_valid = 1; wb_addr = 4'(a); wb_data = W'(d); wb_cout = c; wb_flag_we = fw;
    endtask

    task automatic test_reset;
        idle();
        rst = 1;
        #1;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %0b want 0", wb_ready); end
        tick();
        tick();
        rst = 0;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", wb_ready); end
        checks++; if (regs_q !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", regs_q); end
        checks++; if (carry_q !== 1'b0 || zero_q !== 1'b0) begin errors++; $display("FAIL reset_flags got c%0b z%0b want 0 0", carry_q, zero_q); end
        checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL reset_pend got %0d want 0", pend_cnt); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd got %h want 0", rd_data); end
    endtask

    task automatic test_single_write;
        idle();
        push_req(5, 1, 1, 1);
        tick();
        wb_valid = 0;
        #1;
        checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL single_pend1 got %0d want 1", pend_cnt); end
        checks++; if (rq(5) !== '0) begin errors++; $display("FAIL single_early got %h want 0", rq(5)); end
        tick();
        checks++; if (rq(5) !== W'(1)) begin errors++; $display("FAIL single_reg5 got %h want 1", rq(5)); end
        checks++; if (carry_q !== 1'b1 || zero_q !== 1'b0) begin errors++; $display("FAIL single_flags got c%0b z%0b want 1 0", carry_q, zero_q); end
        checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL single_pend0 got %0d want 0", pend_cnt); end
    endtask

    task automatic test_fill_hold;
        logic [16*W-1:0] snap;
        idle();
        snap = regs_q;
        hold = 1;
        push_req(2, 3, 0, 0);
        tick();
        push_req(3, 5, 0, 0);
        tick();
        push_req(4, 7, 0, 0);
        #1;
        checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL fill_pend got %0d want 2", pend_cnt); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", wb_ready); end
        tick();
        checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL fill_third got %0d want 2", pend_cnt); end
        checks++; if (regs_q !== snap) begin errors++; $display("FAIL fill_regs got %h want %h", regs_q, snap); end
        wb_valid = 0;
        hold = 0;
        tick();
        checks++; if (rq(2) !== W'(3) || rq(3) !== '0) begin errors++; $display("FAIL fill_first got r2=%h r3=%h want 3 0", rq(2), rq(3)); end
        checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL fill_pend_after got %0d want 1", pend_cnt); end
        tick();
        checks++; if (rq(3) !== W'(5) || rq(4) !== '0) begin errors++; $display("FAIL fill_second got r3=%h r4=%h want 5 0", rq(3), rq(4)); end
        checks++; if (pend_cnt !== 2'd0 || carry_q !== 1'b1) begin errors++; $display("FAIL fill_end got p%0d c%0b want 0 1", pend_cnt, carry_q); end
    endtask

    task automatic test_same_addr;
        idle();
        push_req(7, 1, 0, 1);
        tick();
        push_req(7, 0, 1, 1);
        tick();
        wb_valid = 0;
        #1;
        checks++; if (rq(7) !== W'(1) || zero_q !== 1'b0 || carry_q !== 1'b0) begin errors++; $display("FAIL same_mid got r7=%h z%0b c%0b want 1 0 0", rq(7), zero_q, carry_q); end
        tick();
        checks++; if (rq(7) !== '0 || zero_q !== 1'b1 || carry_q !== 1'b1) begin errors++; $display("FAIL same_end got r7=%h z%0b c%0b want 0 1 1", rq(7), zero_q, carry_q); end
    endtask

    task automatic test_push_commit;
        idle();
        push_req(10, 2, 0, 0);
        tick();
        push_req(11, 4, 0, 0);
        #1;
        checks++; if (pend_cnt !== 2'd1 || wb_ready !== 1'b1) begin errors++; $display("FAIL pc_pre got p%0d r%0b want 1 1", pend_cnt, wb_ready); end
        tick();
        wb_valid = 0;
        #1;
        checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL pc_pend got %0d want 1", pend_cnt); end
        checks++; if (rq(10) !== W'(2) || rq(11) !== '0) begin errors++; $display("FAIL pc_order got r10=%h r11=%h want 2 0", rq(10), rq(11)); end
        tick();
        checks++; if (rq(11) !== W'(4) || pend_cnt !== 2'd0) begin errors++; $display("FAIL pc_end got r11=%h p%0d want 4 0", rq(11), pend_cnt); end
    endtask

    task automatic test_clear;
        idle();
        hold = 1;
        push_req(12, 6, 1, 1);
        tick();
        push_req(13, 9, 1, 1);
        tick();
        push_req(14, 1, 1, 1);
        clr = 1;
        #1;
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %0b want 0", wb_ready); end
        tick();
        idle();
        #1;
        checks++; if (regs_q !== '0 || carry_q !== 1'b0 || zero_q !== 1'b0) begin errors++; $display("FAIL clr_state got %h c%0b z%0b want 0", regs_q, carry_q, zero_q); end
        checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL clr_pend got %0d want 0", pend_cnt); end
        // clear with an empty queue while a request is offered: it must vanish
        push_req(1, 5, 1, 1);
        clr = 1;
        tick();
        idle();
        tick();
        tick();
        checks++; if (regs_q !== '0 || pend_cnt !== 2'd0 || carry_q !== 1'b0) begin errors++; $display("FAIL clr_drop got %h p%0d c%0b want 0", regs_q, pend_cnt, carry_q); end
    endtask

    task automatic test_bypass;
        idle();
        hold = 1;
        rd_addr = 9;
        push_req(9, 1, 0, 0);
        tick();
        wb_valid = 0;
        #1;
        checks++; if (rd_data !== (BYP ? W'(1) : W'(0))) begin errors++; $display("FAIL bypass_fwd got %h want %h", rd_data, BYP ? W'(1) : W'(0)); end
        checks++; if (rq(9) !== '0) begin errors++; $display("FAIL bypass_regs got %h want 0", rq(9)); end
        hold = 0;
        tick();
        checks++; if (rd_data !== W'(1) || rq(9) !== W'(1)) begin errors++; $display("FAIL bypass_commit got rd=%h r9=%h want 1 1", rd_data, rq(9)); end
    endtask

    task automatic test_random;
        logic [16*W-1:0] exp_flat;
        logic [W-1:0]    exp_rd;
        logic            exp_ready, acc;
        ment_t           e;
        idle();
        rst = 1;
        tick();
        rst = 0;
        mq.delete();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mc = 0;
        mz = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            rst        = ($urandom_range(0, 59) == 0);
            clr        = ($urandom_range(0, 39) == 0);
            wb_valid   = ($urandom_range(0, 9) < 7);
            hold       = ($urandom_range(0, 9) < 3);
            wb_addr    = 4'($urandom_range(0, 5));
            wb_data    = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
            wb_cout    = 1'($urandom_range(0, 1));
            wb_flag_we = 1'($urandom_range(0, 1));
            rd_addr    = 4'($urandom_range(0, 5));
            #1;
            exp_ready = (mq.size() < 2) && !rst && !clr;
            exp_rd = mregs[rd_addr];
            if (BYP) begin
                foreach (mq[k]) if (mq[k].addr == rd_addr) exp_rd = mq[k].data;
            end
            for (int i = 0; i < 16; i++) exp_flat[i*W +: W] = mregs[i];
            checks++; if (regs_q !== exp_flat) begin errors++; $display("FAIL rnd_regs cyc%0d got %h want %h", cyc, regs_q, exp_flat); end
            checks++; if (carry_q !== mc) begin errors++; $display("FAIL rnd_carry cyc%0d got %0b want %0b", cyc, carry_q, mc); end
            checks++; if (zero_q !== mz) begin errors++; $display("FAIL rnd_zero cyc%0d got %0b want %0b", cyc, zero_q, mz); end
            checks++; if (pend_cnt !== 2'(mq.size())) begin errors++; $display("FAIL rnd_pend cyc%0d got %0d want %0d", cyc, pend_cnt, mq.size()); end
            checks++; if (wb_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc%0d got %0b want %0b", cyc, wb_ready, exp_ready); end
            checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rnd_rd cyc%0d got %h want %h", cyc, rd_data, exp_rd); end
            if (rst || clr) begin
                mq.delete();
                for (int i = 0; i < 16; i++) mregs[i] = '0;
                mc = 0;
                mz = 0;
            end else begin
                acc = wb_valid && (mq.size() < 2);
                if (mq.size() > 0 && !hold) begin
                    e = mq.pop_front();
                    mregs[e.addr] = e.data;
                    if (e.fw) begin
                        mc = e.cout;
                        mz = (e.data == '0);
                    end
                end
                if (acc) begin
                    e.addr = wb_addr; e.data = wb_data; e.cout = wb_cout; e.fw = wb_flag_we;
                    mq.push_back(e);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_write();
        test_fill_hold();
        test_same_addr();
        test_push_commit();
        test_clear();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
